// File: rtl/fifo_mon_test.sv
// fifo_mon_test: FIFO exerciser for the board test designs.
//   2^W-deep x B-bit FIFO, show-ahead read, occupancy counter, programmable
//   almost-full / almost-empty flags, synchronous flush and sticky
//   overflow / underflow error flags. Button ticks drive wr/rd/clr and the
//   status outputs go straight to LEDs.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   wr_tick      one-cycle write request
//   rd_tick      one-cycle pop request
//   clr_tick     one-cycle synchronous flush (wins over wr/rd)
//   w_data[B]    data stored on an accepted write
//   r_data[B]    head entry, 0 when empty
//   count[W+1]   occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty   status from registered count
//   ovf_err      sticky: write while full with no read
//   udf_err      sticky: read while empty
//
// Optional feature macro: FIFO_MON_ERR_EN
//   defined   -> ovf_err / udf_err registers are built
//   undefined -> ovf_err / udf_err tied to 0
module fifo_mon_test #(
  parameter int B         = 8,
  parameter int W         = 4,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_tick,
  input  logic         rd_tick,
  input  logic         clr_tick,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic [W:0]   count,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic         ovf_err,
  output logic         udf_err
);

  localparam int         DEPTH   = 1 << W;
  localparam logic [W:0] DEPTH_C = (W+1)'(DEPTH);
  localparam logic [W:0] AF_TH   = (W+1)'(DEPTH - AF_MARGIN);
  localparam logic [W:0] AE_TH   = (W+1)'(AE_MARGIN);
  localparam logic [W-1:0] PTR_ONE = W'(1);
  localparam logic [W:0]   CNT_ONE = (W+1)'(1);

  logic [B-1:0] mem [DEPTH];
  logic [W-1:0] w_ptr, r_ptr;
  logic [W:0]   cnt;
  logic         wr_ok, rd_ok;

  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_TH);
  assign almost_empty = (cnt <= AE_TH);
  assign count        = cnt;
  assign r_data       = empty ? '0 : mem[r_ptr];

  // A write into a full FIFO still lands when a pop frees the slot in the
  // same cycle. A read on an empty FIFO never bypasses a same-cycle write.
  assign wr_ok = !clr_tick && wr_tick && (!full || rd_tick);
  assign rd_ok = !clr_tick && rd_tick && !empty;

  // Storage is deliberately not reset; r_data masks it while empty.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[w_ptr] <= w_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt   <= '0;
    end else if (clr_tick) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt   <= '0;
    end else begin
      // pointers wrap modulo DEPTH by natural overflow
      if (wr_ok) w_ptr <= w_ptr + PTR_ONE;
      if (rd_ok) r_ptr <= r_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef FIFO_MON_ERR_EN
  logic ovf_q, udf_q;
  logic ovf_ev, udf_ev;

  assign ovf_ev = wr_tick && full && !rd_tick;
  assign udf_ev = rd_tick && empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (clr_tick) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_ev) ovf_q <= 1'b1;
      if (udf_ev) udf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`else
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule

// File: doc/fifo_mon_test.md
Name: fifo_mon_test

Overview:
Parametrised FIFO exerciser for the board test designs. It contains its own 2^W-deep by B-bit FIFO with an occupancy counter, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. Debounced button ticks drive write, read and flush; switches supply write data. The status outputs drive board LEDs directly.

Parameters:
B, 8, data width in bits (>=1)
W, 4, address width; depth DEPTH = 2^W (W>=1)
AF_MARGIN, 1, almost_full asserts when count >= DEPTH - AF_MARGIN (0 <= AF_MARGIN < DEPTH)
AE_MARGIN, 1, almost_empty asserts when count <= AE_MARGIN (0 <= AE_MARGIN < DEPTH)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
wr_tick  in  1  one-cycle write request (from debouncer db_tick)
rd_tick  in  1  one-cycle read/pop request
clr_tick  in  1  one-cycle synchronous flush request
w_data  in  B  data written on an accepted write
r_data  out  B  head-of-FIFO entry (show-ahead); 0 when empty
count  out  W+1  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= DEPTH - AF_MARGIN
almost_empty  out  1  count <= AE_MARGIN
ovf_err  out  1  sticky: write attempted while full without a read
udf_err  out  1  sticky: read attempted while empty

Behaviour:
- Reset (reset=0, async): w_ptr=0, r_ptr=0, count=0, ovf_err=0, udf_err=0. Outputs therefore read empty=1, full=0, almost_empty=1, almost_full=(AF_MARGIN>=DEPTH ? 1 : 0), which is 0 for legal parameters, r_data=0. Storage array is not reset.
- State is w_ptr[W-1:0], r_ptr[W-1:0] and count[W:0]. Both pointers wrap modulo DEPTH by natural overflow. All status outputs are combinational from the registered count.
- Priority per cycle: clr_tick > {rd_tick, wr_tick}.
- clr_tick=1: w_ptr, r_ptr and count go to 0. ovf_err and udf_err clear. rd/wr in the same cycle are ignored and flag nothing. Storage is untouched.
- The table below covers clr_tick=0 (F=full, E=empty before the edge):
  - wr only, !F: store w_data at w_ptr, w_ptr+1, count+1.
  - wr only, F: write dropped, ovf_err<=1.
  - rd only, !E: r_ptr+1, count-1.
  - rd only, E: ignored, udf_err<=1.
  - wr&rd, !E&!F: both accepted, count unchanged.
  - wr&rd, F: both accepted (the pop frees a slot), count stays DEPTH, no ovf.
  - wr&rd, E: write accepted, read ignored (no bypass), count=1, udf_err<=1.
- Latency: a write accepted at edge k is visible on r_data, empty and count immediately after edge k. A pop at edge k advances r_data after edge k.
- r_data = empty ? 0 : mem[r_ptr]. The memory write port is synchronous and the read is asynchronous.
- count never exceeds DEPTH or wraps below 0 under any input sequence.
- Reset asserted mid-operation forces the reset state immediately. Deassertion takes effect on the next clk edge.

Optional Feature:
FIFO_MON_ERR_EN. When it is defined, ovf_err and udf_err behave as described above. When it is undefined, both outputs are tied to 0, the error registers are not built, and all other behaviour is identical.

Test Plan:
- B=3,W=2. Release reset -> empty=1, full=0, count=0, r_data=0, almost_empty=1, errors 0.
- Write 5,3,6,1 (one tick each) -> after the 4th write count=4, full=1, almost_full=1 (from count 3 on). The 5th write of 7 -> count stays 4, ovf_err=1 (macro on) or 0 (macro off). Pop four times -> r_data shows 5,3,6,1 in order, then empty=1 and r_data=0.
- With 4 entries, assert wr_tick(w_data=2) and rd_tick together -> count stays 4, ovf_err unchanged, head advances. After draining, the last value popped is 2, confirming pointer wrap.
- When empty, pulse rd_tick -> count=0 and udf_err=1. On the same empty FIFO, pulse wr(4)&rd together -> count=1, r_data=4, udf_err=1.
- With 3 entries and errors set, pulse clr_tick together with wr_tick -> count=0, empty=1, both errors 0, the write is dropped.
- Assert reset mid-burst (count=2) asynchronously between edges -> outputs return to reset values before the next clk edge.
